lite_reg_slave: RTL and testbench

- NASTI-Lite slave endpoint sitting directly downstream of the NASTI-to-Lite bridge.
- Consumes the bridge's lite master channel and turns each single-beat read or write into one request on a simple register bus (req/ack) for peripheral register files.
- Serialises traffic: one outstanding transaction, with round-robin arbitration between reads and writes.
- Generates AXI-style response codes.

---
 rtl/lite_reg_slave_if.sv | 34 +++
 rtl/lite_reg_slave.sv | 113 +++++++++++
 tb/tb_lite_reg_slave.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lite_reg_slave_if.sv
// lite_reg_slave_if: nasti_channel lite port bundle carrying the aw/w/b/ar/r single-beat channels.
interface nasti_channel #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1
);
    logic                    aw_valid, aw_ready;
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic                    w_valid, w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    b_valid, b_ready;
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    ar_valid, ar_ready;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic                    r_valid, r_ready, r_last;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic [USER_WIDTH-1:0]   r_user;
    modport master (
        output aw_valid, aw_id, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_id, ar_addr, r_ready,
        input  aw_ready, w_ready, b_valid, b_id, b_resp, b_user, ar_ready, r_valid, r_id, r_data, r_resp, r_last, r_user
    );
    modport slave (
        input  aw_valid, aw_id, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_id, ar_addr, r_ready,
        output aw_ready, w_ready, b_valid, b_id, b_resp, b_user, ar_ready, r_valid, r_id, r_data, r_resp, r_last, r_user
    );
endinterface

// File: rtl/lite_reg_slave.sv
// lite_reg_slave: NASTI-Lite slave turning single-beat reads/writes into req/ack register bus accesses.
// Define LITE_REG_TIMEOUT_EN to answer SLVERR when reg_ack does not arrive within TIMEOUT cycles.
module lite_reg_slave #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int REG_SPAN   = 256,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    nasti_channel.slave             lite_s,
    output logic                    reg_req,
    output logic                    reg_we,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb,
    input  logic                    reg_ack,
    input  logic [DATA_WIDTH-1:0]   reg_rdata,
    input  logic                    reg_err
);
    localparam int SW = DATA_WIDTH / 8;
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $fatal(1, "lite_reg_slave: DATA_WIDTH must be 32 or 64");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $fatal(1, "lite_reg_slave: TIMEOUT must be at least 1");
    end
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t                state;
    logic                  rd_pri, is_rd;
    logic [ID_WIDTH-1:0]   id_q;
    logic [1:0]            resp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  wr_el, rd_el, grant_rd, grant_wr, dec_err, timed_out;
    logic [ADDR_WIDTH-1:0] addr;
    always_comb begin
        wr_el    = lite_s.aw_valid & lite_s.w_valid;
        rd_el    = lite_s.ar_valid;
        grant_rd = state == IDLE && rd_el && (!wr_el || rd_pri);
        grant_wr = state == IDLE && wr_el && !grant_rd;
        addr     = grant_rd ? lite_s.ar_addr : lite_s.aw_addr;
        dec_err  = {1'b0, addr} >= (ADDR_WIDTH + 1)'(REG_SPAN);
    end
    assign lite_s.ar_ready = grant_rd;
    assign lite_s.aw_ready = grant_wr;
    assign lite_s.w_ready  = grant_wr;
    assign lite_s.b_valid  = state == RESP && !is_rd;
    assign lite_s.b_id     = id_q;
    assign lite_s.b_resp   = resp_q;
    assign lite_s.b_user   = USER_WIDTH'(0);
    assign lite_s.r_valid  = state == RESP && is_rd;
    assign lite_s.r_id     = id_q;
    assign lite_s.r_data   = rdata_q;
    assign lite_s.r_resp   = resp_q;
    assign lite_s.r_last   = 1'b1;
    assign lite_s.r_user   = USER_WIDTH'(0);
`ifdef LITE_REG_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    assign timed_out = state == REQ && cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        cnt <= (rst || state != REQ) ? '0 : cnt + 1'b1;
    end
`else
    assign timed_out = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_pri    <= 1'b1;
            is_rd     <= 1'b0;
            id_q      <= '0;
            resp_q    <= '0;
            rdata_q   <= '0;
            reg_req   <= 1'b0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wstrb <= '0;
        end else begin
            case (state)
                IDLE: if (grant_rd || grant_wr) begin
                    is_rd   <= grant_rd;
                    id_q    <= grant_rd ? lite_s.ar_id : lite_s.aw_id;
                    rdata_q <= '0;
                    if (rd_el && wr_el) rd_pri <= !rd_pri;
                    if (dec_err) begin
                        resp_q <= 2'b11;
                        state  <= RESP;
                    end else begin
                        reg_req   <= 1'b1;
                        reg_we    <= grant_wr;
                        reg_addr  <= addr & ~ADDR_WIDTH'(SW - 1);
                        reg_wdata <= grant_wr ? lite_s.w_data : '0;
                        reg_wstrb <= grant_wr ? lite_s.w_strb : '0;
                        state     <= REQ;
                    end
                end
                // an ack in the timeout cycle still wins
                REQ: if (reg_ack || timed_out) begin
                    reg_req <= 1'b0;
                    resp_q  <= reg_ack && !reg_err ? 2'b00 : 2'b10;
                    if (reg_ack && !reg_we) rdata_q <= reg_rdata;
                    state   <= RESP;
                end
                RESP: if (is_rd ? lite_s.r_ready : lite_s.b_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lite_reg_slave.sv
// tb_lite_reg_slave: randomized scoreboard bench for lite_reg_slave against a register-file reference model.
module tb_lite_reg_slave;
    localparam int AW = 12;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    nasti_channel #(.ID_WIDTH(1), .ADDR_WIDTH(AW), .DATA_WIDTH(32), .USER_WIDTH(1)) lite ();
    logic          reg_req, reg_we, reg_ack, reg_err;
    logic [AW-1:0] reg_addr;
    logic [31:0]   reg_wdata, reg_rdata;
    logic [3:0]    reg_wstrb;
    lite_reg_slave #(.ID_WIDTH(1), .ADDR_WIDTH(AW), .DATA_WIDTH(32), .USER_WIDTH(1),
                     .REG_SPAN(256), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .lite_s(lite), .reg_req(reg_req), .reg_we(reg_we),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
        .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
    );
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wstrb;
        int            mode;
    } plan_t;
    typedef struct {
        bit          rd;
        logic        id;
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;
    plan_t       plan_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] ref_mem[64];
    logic [31:0] pmem[64];
    bit          ptr_rd = 1;
    bit          force_stall = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic bit is_err(input logic [AW-1:0] a);
        return a < 256 && a[7:2] == 6'h3C;
    endfunction
    // mode: 0 normal, 1 dropped by reset, 2 never acked
    task automatic expect_txn(input bit rd, input logic [AW-1:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic id, input int mode);
        plan_t p;
        rsp_t  r;
        bit    dec;
        int    w;
        dec = a >= 256;
        w = int'(a[7:2]);
        if (!dec) begin
            p.we = !rd; p.addr = a & ~12'h3; p.wdata = rd ? 32'h0 : d;
            p.wstrb = rd ? 4'h0 : s; p.mode = mode;
            plan_q.push_back(p);
        end
        if (mode == 1) return;
        r.rd = rd;
        r.id = id;
        r.resp = dec ? 2'b11 : (mode == 2 || is_err(a)) ? 2'b10 : 2'b00;
        r.data = (rd && !dec && mode != 2) ? ref_mem[w] : 32'h0;
        if (!rd && r.resp == 2'b00)
            for (int b = 0; b < 4; b++) if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
        rsp_q.push_back(r);
    endtask
    task automatic issue(input bit do_rd, input bit do_wr, input logic [AW-1:0] ra, input logic rid,
                         input logic [AW-1:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                         input logic wid, input int mode);
        bit rd_done, wr_done, grd, gwr, rd_first;
        int n;
        rd_first = do_rd && (!do_wr || ptr_rd);
        if (do_rd && do_wr) ptr_rd = !ptr_rd;
        if (rd_first) expect_txn(1, ra, 0, 0, rid, mode);
        if (do_wr) expect_txn(0, wa, wd, ws, wid, mode);
        if (do_rd && !rd_first) expect_txn(1, ra, 0, 0, rid, mode);
        rd_done = !do_rd;
        wr_done = !do_wr;
        n = 0;
        while (!(rd_done && wr_done)) begin
            @(negedge clk);
            lite.ar_valid = !rd_done; lite.ar_addr = ra; lite.ar_id = rid;
            lite.aw_valid = !wr_done; lite.aw_addr = wa; lite.aw_id = wid;
            lite.w_valid = !wr_done; lite.w_data = wd; lite.w_strb = ws;
            #1;
            grd = lite.ar_valid && lite.ar_ready;
            gwr = lite.aw_valid && lite.aw_ready && lite.w_valid && lite.w_ready;
            @(posedge clk);
            rd_done |= grd;
            wr_done |= gwr;
            if (++n > 500) begin
                chk("handshake_timeout", {rd_done, wr_done}, 2'b11);
                break;
            end
        end
        @(negedge clk);
        lite.ar_valid = 0; lite.aw_valid = 0; lite.w_valid = 0;
    endtask
    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || plan_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 64'(rsp_q.size() + plan_q.size()), 0);
    endtask
    function automatic logic [54:0] outs();
        return {reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb, lite.aw_ready, lite.w_ready,
                lite.ar_ready, lite.b_valid, lite.r_valid};
    endfunction
    // register-file peripheral on the req/ack side, also injecting stray acks while idle
    initial begin
        plan_t p;
        int    n;
        reg_ack = 0; reg_err = 0; reg_rdata = 0;
        for (int i = 0; i < 64; i++) pmem[i] = 0;
        forever begin
            @(negedge clk);
            reg_ack = 0;
            reg_err = 0;
            if (rst) continue;
            if (reg_req) begin
                if (plan_q.size() == 0) begin
                    chk("unexpected_req", {reg_we, reg_addr}, 0);
                    n = 0;
                    while (reg_req && n < 50) begin @(negedge clk); n++; end
                    continue;
                end
                p = plan_q.pop_front();
                chk("reg_request", {reg_we, reg_addr, reg_wdata, reg_wstrb}, {p.we, p.addr, p.wdata, p.wstrb});
                if (p.mode == 1) begin
                    n = 0;
                    while (!rst && n < 100) begin @(negedge clk); n++; end
                    while (rst) @(negedge clk);
                    reg_ack = 1; reg_rdata = 32'hBAD0BAD0;
                end else if (p.mode == 2) begin
                    n = 0;
                    while (reg_req && n < 50) begin @(negedge clk); n++; end
                end else begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    reg_ack = 1;
                    reg_err = is_err(reg_addr);
                    reg_rdata = pmem[reg_addr[7:2]];
                    if (reg_we && !reg_err)
                        for (int b = 0; b < 4; b++)
                            if (reg_wstrb[b]) pmem[reg_addr[7:2]][8*b +: 8] = reg_wdata[8*b +: 8];
                end
            end else if ($urandom_range(0, 7) == 0) begin
                reg_ack = 1; reg_err = 1'($urandom); reg_rdata = $urandom;
            end
        end
    end
    // response monitor with random backpressure and stability checking
    initial begin
        logic        bv, rv, bid, rid, last, bu, ru, stable;
        logic [1:0]  br, rr;
        logic [31:0] rd;
        rsp_t        e;
        lite.b_ready = 0;
        lite.r_ready = 0;
        forever begin
            @(negedge clk);
            if (!rst && (lite.b_valid || lite.r_valid)) begin
                bv = lite.b_valid; rv = lite.r_valid; bid = lite.b_id; rid = lite.r_id;
                br = lite.b_resp; rr = lite.r_resp; rd = lite.r_data; last = lite.r_last;
                bu = lite.b_user; ru = lite.r_user;
                stable = 1;
                repeat (force_stall ? 5 : $urandom_range(0, 3)) begin
                    @(negedge clk);
                    if ({bv, rv, bid, rid, br, rr, rd} !== {lite.b_valid, lite.r_valid, lite.b_id,
                        lite.r_id, lite.b_resp, lite.r_resp, lite.r_data}) stable = 0;
                end
                lite.b_ready = bv;
                lite.r_ready = rv;
                @(negedge clk);
                lite.b_ready = 0;
                lite.r_ready = 0;
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", {bv, rv}, 0);
                    continue;
                end
                e = rsp_q.pop_front();
                chk("rsp_kind", {bv, rv}, e.rd ? 2'b01 : 2'b10);
                chk("rsp_id", rv ? rid : bid, e.id);
                chk("rsp_resp", rv ? rr : br, e.resp);
                if (e.rd) chk("rsp_rdata", rd, e.data);
                chk("rsp_last_user", {last, bu, ru}, 3'b100);
                chk("rsp_stable", stable, 1);
            end
        end
    end
    // AW and W must only ever be accepted together
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst && (lite.aw_ready || lite.w_ready))
            chk("aw_w_pair", {lite.aw_ready, lite.w_ready, lite.aw_valid, lite.w_valid}, 4'hF);
    end
    initial begin
        int n;
        for (int i = 0; i < 64; i++) ref_mem[i] = 0;
        lite.ar_valid = 0; lite.aw_valid = 0; lite.w_valid = 0;
        lite.ar_addr = 0; lite.aw_addr = 0; lite.ar_id = 0; lite.aw_id = 0;
        lite.w_data = 0; lite.w_strb = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        rst = 0;
        issue(0, 1, 0, 0, 12'h010, 32'hDEADBEEF, 4'hF, 1, 0);
        issue(0, 1, 0, 0, 12'h010, 32'h12345678, 4'hF, 0, 0);
        issue(1, 0, 12'h013, 1, 0, 0, 0, 0, 0);
        issue(0, 1, 0, 0, 12'h024, 32'hCAFEF00D, 4'h5, 1, 0);
        repeat (3) issue(1, 1, 12'h024, 0, 12'h020, 32'hA5A5A5A5, 4'hF, 1, 0);
        issue(1, 0, 12'h100, 1, 0, 0, 0, 0, 0);
        drain();
        force_stall = 1;
        issue(0, 1, 0, 0, 12'h0F0, 32'h11111111, 4'hF, 1, 0);
        drain();
        force_stall = 0;
        issue(0, 1, 0, 0, 12'h030, 32'h77777777, 4'hF, 0, 1);
        n = 0;
        while (!reg_req && n < 100) begin @(negedge clk); n++; end
        chk("req_before_reset", reg_req, 1);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        ptr_rd = 1;
        repeat (4) @(negedge clk);
        chk("outputs_after_reset", outs(), 0);
        repeat (10) @(negedge clk);
        issue(1, 1, 12'h030, 1, 12'h034, 32'h0BADCAFE, 4'hC, 0, 0);
        drain();
`ifdef LITE_REG_TIMEOUT_EN
        issue(1, 0, 12'h040, 1, 0, 0, 0, 0, 2);
        drain();
`endif
        for (int i = 0; i < 80; i++) begin
            int op;
            op = $urandom_range(0, 3);
            issue(op != 1, op >= 1, AW'($urandom_range(0, 12'h13F)), 1'($urandom),
                  AW'($urandom_range(0, 12'h13F)), $urandom, 4'($urandom), 1'($urandom), 0);
        end
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
